relin_tile_host: RTL and testbench
==================================

// Module: relin_tile_host
// PURPOSE
//  Host-side partner of the relinearization unit. Latches a full c2 polynomial, streams it
//  out as TILE_N-coefficient tiles on a valid/ready handshake, then collects the c0 and c1
//  result tiles (key_select 0 then 1, one beat per cycle, no backpressure). Re-assembles
//  them into full polynomials. Sits between the ciphertext register file and the relin core.
// PARAMETERS
//  DEGREE_N   `DEGREE_N   coefficients per polynomial
//  TILE_N     `TILE_N     coefficients per tile; DEGREE_N % TILE_N == 0
//  BIT_WIDTH  `BIT_WIDTH  bits per coefficient
//  TIMEOUT    4096        max cycles in WAIT_RES with no result beat before error
// PORTS
//  clk             in   1                      clock
//  rst             in   1                      synchronous reset, active-low
//  start_i         in   1                      1-cycle pulse: latch poly_i and begin
//  poly_i          in   DEGREE_N*BIT_WIDTH     c2 polynomial, [DEGREE_N-1:0][BIT_WIDTH-1:0]
//  busy_o          out  1                      high in every state except IDLE
//  done_o          out  1                      1-cycle pulse when c0_o/c1_o are complete
//  err_o           out  1                      sticky: timeout or key-order fault; cleared by start_i
//  tile_valid_o    out  1                      tile_o holds a valid c2 tile
//  tile_ready_i    in   1                      relin core accepts the tile
//  tile_o          out  TILE_N*BIT_WIDTH       c2 tile; tile k = coeffs [k*TILE_N +: TILE_N]
//  res_valid_i     in   1                      result beat present this cycle
//  res_key_sel_i   in   1                      0 = beat belongs to c0, 1 = beat belongs to c1
//  res_coeff_i     in   TILE_N*BIT_WIDTH       result tile
//  c0_o, c1_o      out  DEGREE_N*BIT_WIDTH     assembled results, held until next start_i
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE. All counters, busy_o, done_o, err_o, tile_valid_o,
//   c0_o, c1_o = 0. Reset mid-operation aborts immediately. Partial results are discarded.
//  NT = DEGREE_N/TILE_N. tx_idx and rx_idx are $clog2(NT+1)-bit counters.
//  IDLE:     on start_i, latch poly_i, clear err_o, tx_idx=0, and go to SEND. start_i is
//            ignored in all other states.
//  SEND:     tile_valid_o=1, tile_o=poly_q[tx_idx]. A transfer occurs when valid&ready.
//            tile_o is stable until the transfer. On the transfer of tile NT-1, go to
//            WAIT_RES with rx_idx=0 and timer=0. Result beats are ignored in SEND.
//  WAIT_RES: on res_valid_i with key_sel=0, write c0[0], set rx_idx=1, and go to RECV_C0.
//            On a beat with key_sel=1, set err_o and go to IDLE.
//            Timer reaching TIMEOUT-1 with no beat: set err_o and go to IDLE.
//  RECV_C0:  on each beat with key_sel=0, write c0_o[rx_idx*TILE_N +: TILE_N] and increment rx_idx.
//            Cycles without res_valid_i are allowed, and rx_idx holds.
//            A key_sel=1 beat when rx_idx==NT: write c1 tile 0, set rx_idx=1, go to RECV_C1.
//            A key_sel=1 beat when rx_idx<NT: set err_o and go to IDLE.
//            A key_sel=0 beat when rx_idx==NT (extra beat): ignored.
//  RECV_C1:  same as RECV_C0 for c1_o. When the NTth c1 beat is written, go to DONE.
//            A key_sel=0 beat in RECV_C1 sets err_o and goes to IDLE.
//  DONE:     done_o=1 for exactly this cycle, then go to IDLE. Beats arriving in DONE or
//            IDLE are ignored. c0_o and c1_o hold their values.
//  Latency (ready always 1, results back-to-back): NT send cycles, then core latency,
//   then 2*NT receive cycles, then 1 cycle in DONE.
//  No arithmetic is done on coefficients; they are copied bit-exact.
// STRUCTURE
//  Package he_tile_pkg: state enum (IDLE, SEND, WAIT_RES, RECV_C0, RECV_C1, DONE),
//   typedefs coeff_t, tile_t, poly_t, and localparam NT.
//  One sub-module, tile_assembler: rx_idx counter plus tile write into poly_t.
//   It is instantiated twice (c0 and c1) with a clear input and a write enable.
//  The FSM, tx counter and timeout timer live in the top module.
// TESTING  (DEGREE_N=16, TILE_N=4, BIT_WIDTH=32)
//  1 Basic: poly_i[i]=i+1, ready=1, model echoes c0[i]=i+100 and c1[i]=i+200 back-to-back
//    -> tile_o seq {1..4},{5..8},{9..12},{13..16}; c0_o/c1_o match; done_o is 1 cycle; err_o=0.
//  2 Backpressure: ready toggles 1,0,0,1... -> tile_o is stable while stalled; exactly 4 transfers.
//  3 Gapped results: res_valid_i low every other cycle -> the same c0/c1 as case 1; done_o once.
//  4 Order fault: key_sel=1 after 2 c0 beats -> err_o=1, back to IDLE, busy_o=0, no done_o.
//  5 Timeout: TIMEOUT=8, no beats -> err_o set 8 cycles after the last tile; the next start_i clears it.
//  6 Reset mid-RECV_C1 (rst=0 for 1 cycle) -> all outputs 0 next cycle; a new start_i runs clean.

Source files
------------

// File: rtl/he_tile_pkg.sv
// he_tile_pkg: sizes, coefficient/tile/polynomial types and FSM states for the relin tile host
`ifndef DEGREE_N
`define DEGREE_N 16
`endif
`ifndef TILE_N
`define TILE_N 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
package he_tile_pkg;
    localparam int DEGREE_N = `DEGREE_N;
    localparam int TILE_N = `TILE_N;
    localparam int BIT_WIDTH = `BIT_WIDTH;
    localparam int NT = DEGREE_N / TILE_N;
    localparam int IDX_W = $clog2(NT + 1);
    localparam int SEL_W = (NT > 1) ? $clog2(NT) : 1;
    typedef logic [BIT_WIDTH-1:0] coeff_t;
    typedef coeff_t [TILE_N-1:0] tile_t;
    typedef coeff_t [DEGREE_N-1:0] poly_t;
    typedef tile_t [NT-1:0] tiles_t;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_RES, RECV_C0, RECV_C1, DONE} state_e;
endpackage

// File: rtl/tile_assembler.sv
// tile_assembler: writes incoming result tiles in order into a full polynomial
module tile_assembler
    import he_tile_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             we_i,
    input  tile_t            tile_i,
    output logic [IDX_W-1:0] idx_o,
    output poly_t            poly_o
);
    logic [IDX_W-1:0] idx_d, idx_q;
    tiles_t acc_d, acc_q;
    always_comb begin
        idx_d = clr_i ? '0 : idx_q + IDX_W'(we_i);
        acc_d = acc_q;
        if (we_i) acc_d[idx_q[SEL_W-1:0]] = tile_i;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end
    assign idx_o = idx_q;
    assign poly_o = poly_t'(acc_q);
endmodule

// File: rtl/relin_tile_host.sv
// relin_tile_host: streams a c2 polynomial out as tiles and reassembles the c0/c1 result tiles
module relin_tile_host
    import he_tile_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start_i,
    input  poly_t poly_i,
    output logic  busy_o,
    output logic  done_o,
    output logic  err_o,
    output logic  tile_valid_o,
    input  logic  tile_ready_i,
    output tile_t tile_o,
    input  logic  res_valid_i,
    input  logic  res_key_sel_i,
    input  tile_t res_coeff_i,
    output poly_t c0_o,
    output poly_t c1_o
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    state_e state_d, state_q;
    logic [IDX_W-1:0] tx_d, tx_q, c0_idx, c1_idx;
    logic [TW-1:0] timer_d, timer_q;
    poly_t poly_d, poly_q;
    tiles_t poly_tiles;
    logic busy_d, busy_q, done_d, done_q, err_d, err_q, valid_d, valid_q;
    logic clr, c0_we, c1_we, beat0, beat1;
    assign beat0 = res_valid_i & ~res_key_sel_i;
    assign beat1 = res_valid_i & res_key_sel_i;
    always_comb begin
        state_d = state_q;
        tx_d = tx_q;
        timer_d = timer_q;
        poly_d = poly_q;
        err_d = err_q;
        clr = 1'b0;
        c0_we = 1'b0;
        c1_we = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                poly_d = poly_i;
                err_d = 1'b0;
                tx_d = '0;
                state_d = SEND;
            end
            SEND: if (tile_ready_i) begin
                tx_d = (tx_q == IDX_W'(NT - 1)) ? '0 : tx_q + IDX_W'(1);
                if (tx_q == IDX_W'(NT - 1)) begin
                    state_d = WAIT_RES;
                    timer_d = '0;
                    clr = 1'b1;
                end
            end
            WAIT_RES: begin
                timer_d = timer_q + TW'(1);
                if (beat0) begin
                    c0_we = 1'b1;
                    state_d = RECV_C0;
                end else if (beat1 || timer_q == TW'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RECV_C0: if (beat1) begin
                if (c0_idx == IDX_W'(NT)) begin
                    c1_we = 1'b1;
                    state_d = (NT == 1) ? DONE : RECV_C1;
                end else begin
                    err_d = 1'b1;
                    state_d = IDLE;
                end
            end else if (beat0 && c0_idx != IDX_W'(NT)) begin
                c0_we = 1'b1;
            end
            RECV_C1: if (beat0) begin
                err_d = 1'b1;
                state_d = IDLE;
            end else if (beat1) begin
                c1_we = 1'b1;
                if (c1_idx == IDX_W'(NT - 1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        valid_d = state_d == SEND;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tx_q <= '0;
            timer_q <= '0;
            poly_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q <= tx_d;
            timer_q <= timer_d;
            poly_q <= poly_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            valid_q <= valid_d;
        end
    end
    // tx_q only reaches NT-1 while sending, so the low bits select the tile
    assign poly_tiles = tiles_t'(poly_q);
    assign tile_o = poly_tiles[tx_q[SEL_W-1:0]];
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o = err_q;
    assign tile_valid_o = valid_q;
    tile_assembler u_c0 (
        .clk(clk), .rst(rst), .clr_i(clr), .we_i(c0_we),
        .tile_i(res_coeff_i), .idx_o(c0_idx), .poly_o(c0_o)
    );
    tile_assembler u_c1 (
        .clk(clk), .rst(rst), .clr_i(clr), .we_i(c1_we),
        .tile_i(res_coeff_i), .idx_o(c1_idx), .poly_o(c1_o)
    );
endmodule

// File: tb/tb_relin_tile_host.sv
// tb_relin_tile_host: directed scoreboard bench for relin_tile_host with a short result timeout
module tb_relin_tile_host;
    import he_tile_pkg::*;
    localparam int TO = 8;
    localparam int PW = DEGREE_N * BIT_WIDTH;
    logic clk = 1'b0, rst = 1'b0, start_i = 1'b0, tile_ready_i = 1'b0;
    logic res_valid_i = 1'b0, res_key_sel_i = 1'b0;
    poly_t poly_i = '0;
    tile_t res_coeff_i = '0;
    logic busy_o, done_o, err_o, tile_valid_o;
    tile_t tile_o;
    poly_t c0_o, c1_o;
    int n_cmp = 0, n_err = 0, done_cnt = 0, done_base = 0;
    tile_t tile_q[$];
    poly_t res_q[$];

    always #5 clk = ~clk;
    always @(negedge clk) if (done_o) done_cnt++;

    relin_tile_host #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .poly_i(poly_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i), .tile_o(tile_o),
        .res_valid_i(res_valid_i), .res_key_sel_i(res_key_sel_i), .res_coeff_i(res_coeff_i),
        .c0_o(c0_o), .c1_o(c1_o)
    );

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic poly_t ramp(input int base);
        poly_t p;
        for (int i = 0; i < DEGREE_N; i++) p[i] = coeff_t'(base + i);
        return p;
    endfunction

    function automatic tile_t tile_of(input poly_t p, input int k);
        tile_t t;
        for (int j = 0; j < TILE_N; j++) t[j] = p[k * TILE_N + j];
        return t;
    endfunction

    function automatic tile_t fill(input coeff_t v);
        tile_t t;
        for (int j = 0; j < TILE_N; j++) t[j] = v;
        return t;
    endfunction

    task automatic do_start(input poly_t p, input bit expect_done);
        @(negedge clk);
        start_i = 1'b1;
        poly_i = p;
        for (int k = 0; k < NT; k++) tile_q.push_back(tile_of(p, k));
        if (expect_done) begin
            res_q.push_back(ramp(100));
            res_q.push_back(ramp(200));
        end
        @(negedge clk);
        start_i = 1'b0;
        poly_i = '0;
        check("busy_after_start", busy_o, 1'b1);
        check("err_after_start", err_o, 1'b0);
    endtask

    task automatic send(input bit stall);
        for (int c = 0; c < 64 && tile_q.size() > 0; c++) begin
            if (c > 0) @(negedge clk);
            tile_ready_i = stall ? (c % 3 == 0) : 1'b1;
            check("tile_valid", tile_valid_o, 1'b1);
            check("tile_data", tile_o, tile_q[0]);
            if (tile_ready_i) void'(tile_q.pop_front());
        end
        if (tile_q.size() > 0) begin
            check("send_budget", tile_q.size(), 0);
            tile_q.delete();
        end
        @(negedge clk);
        tile_ready_i = 1'b0;
        check("tile_valid_drop", tile_valid_o, 1'b0);
    endtask

    task automatic recv(input bit gap, input bit extra, input int fault_after, input int limit);
        tile_t beats[$];
        bit keys[$];
        int n0, i;
        n0 = (fault_after >= 0) ? fault_after : NT;
        i = 0;
        for (int k = 0; k < n0; k++) begin
            beats.push_back(tile_of(ramp(100), k));
            keys.push_back(1'b0);
        end
        if (extra) begin
            beats.push_back(fill(32'hbad0_0000));
            keys.push_back(1'b0);
        end
        if (fault_after >= 0) begin
            beats.push_back(fill(32'hbad1_1111));
            keys.push_back(1'b1);
        end else begin
            for (int k = 0; k < NT; k++) begin
                beats.push_back(tile_of(ramp(200), k));
                keys.push_back(1'b1);
            end
        end
        done_base = done_cnt;
        for (int cyc = 0; cyc < 64 && i < beats.size() && i < limit; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (gap && (cyc % 2 == 1)) begin
                res_valid_i = 1'b0;
                res_key_sel_i = 1'b1;
                res_coeff_i = fill(32'hdead_beef);
            end else begin
                res_valid_i = 1'b1;
                res_key_sel_i = keys[i];
                res_coeff_i = beats[i];
                i++;
            end
        end
        @(negedge clk);
        res_valid_i = 1'b0;
        res_key_sel_i = 1'b0;
        res_coeff_i = '0;
    endtask

    task automatic finish_ok();
        poly_t e0, e1;
        check("done_pulse", done_o, 1'b1);
        check("err_clean", err_o, 1'b0);
        @(negedge clk);
        check("done_width", done_o, 1'b0);
        check("busy_idle", busy_o, 1'b0);
        check("done_count", done_cnt - done_base, 1);
        if (res_q.size() < 2) begin
            check("res_queue", res_q.size(), 2);
        end else begin
            e0 = res_q.pop_front();
            e1 = res_q.pop_front();
            check("c0_poly", c0_o, e0);
            check("c1_poly", c1_o, e1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_valid", tile_valid_o, 1'b0);
        check("rst_c0", c0_o, '0);
        check("rst_c1", c1_o, '0);
        rst = 1'b1;
        // basic back-to-back run
        do_start(ramp(1), 1'b1);
        send(1'b0);
        recv(1'b0, 1'b0, -1, 99);
        finish_ok();
        // ready stalls 1,0,0,1...
        do_start(ramp(21), 1'b1);
        send(1'b1);
        recv(1'b0, 1'b0, -1, 99);
        finish_ok();
        // gapped results with one surplus c0 beat that must be ignored
        do_start(ramp(41), 1'b1);
        send(1'b0);
        recv(1'b1, 1'b1, -1, 99);
        finish_ok();
        // key order fault after two c0 beats
        do_start(ramp(61), 1'b0);
        send(1'b0);
        recv(1'b0, 1'b0, 2, 99);
        check("fault_err", err_o, 1'b1);
        check("fault_busy", busy_o, 1'b0);
        check("fault_done", done_o, 1'b0);
        @(negedge clk);
        check("fault_no_done", done_cnt - done_base, 0);
        check("fault_err_sticky", err_o, 1'b1);
        // timeout with no beats, then a clean run clears err
        do_start(ramp(81), 1'b0);
        send(1'b0);
        repeat (TO - 1) @(negedge clk);
        check("timeout_early_err", err_o, 1'b0);
        check("timeout_early_busy", busy_o, 1'b1);
        @(negedge clk);
        check("timeout_err", err_o, 1'b1);
        check("timeout_busy", busy_o, 1'b0);
        do_start(ramp(1), 1'b1);
        send(1'b0);
        recv(1'b0, 1'b0, -1, 99);
        finish_ok();
        // reset in the middle of RECV_C1
        do_start(ramp(5), 1'b0);
        send(1'b0);
        recv(1'b0, 1'b0, -1, NT + 2);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_err", err_o, 1'b0);
        check("mid_rst_valid", tile_valid_o, 1'b0);
        check("mid_rst_tile", tile_o, '0);
        check("mid_rst_c0", c0_o, '0);
        check("mid_rst_c1", c1_o, '0);
        rst = 1'b1;
        do_start(ramp(9), 1'b1);
        send(1'b0);
        recv(1'b0, 1'b0, -1, 99);
        finish_ok();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
